alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 45 ++++
 rtl/alu_sequencer_alu.sv | 34 +++
 rtl/alu_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared constants, opcode/state encodings and request record
//               for the ALU sequencer and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int REG_AW  = 3;

  // ALU opcodes
  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_AND     = 3'd2;
  localparam logic [2:0] OP_OR      = 3'd3;
  localparam logic [2:0] OP_XOR     = 3'd4;
  localparam logic [2:0] OP_SHL     = 3'd5;
  localparam logic [2:0] OP_SHR     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Sequencer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Request fields captured on accept
  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
  } req_t;

  // True for the two shift opcodes
  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Purely combinational 16-bit ALU. Shifts use only the low four
//               bits of B; out-of-range shifts and the illegal opcode are
//               resolved by the sequencer around this block.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
  import alu_sequencer_pkg::*;
(
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  input  logic        [2:0]        ALUOp,
  output logic signed [DATA_W-1:0] ALUOut
);

  // Opcode decode; add/sub wrap naturally at 16 bits
  always_comb begin
    ALUOut = '0;
    case (ALUOp)
      OP_ADD:  ALUOut = A + B;
      OP_SUB:  ALUOut = A - B;
      OP_AND:  ALUOut = A & B;
      OP_OR:   ALUOut = A | B;
      OP_XOR:  ALUOut = A ^ B;
      OP_SHL:  ALUOut = $signed($unsigned(A) << B[3:0]);
      OP_SHR:  ALUOut = $signed($unsigned(A) >> B[3:0]);
      default: ALUOut = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Three-state (IDLE/EXEC/RESP) request sequencer around an ALU
//               with an 8 x 16 register file (R0 hard-wired to zero) and a
//               combinational debug read port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        ReqOp,
  input  logic [2:0]        ReqRd,
  input  logic [2:0]        ReqRs1,
  input  logic [2:0]        ReqRs2,
  input  logic              ReqUseImm,
  input  logic [15:0]       ReqImm,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [15:0]       RspData,
  output logic [2:0]        RspRd,
  output logic              RspErr,
  output logic              RspZero,
  output logic              RspNeg,
  input  logic [2:0]        DbgAddr,
  output logic [15:0]       DbgData
);

  logic [1:0]        state_q, state_d;
  req_t              req_q;
  logic [DATA_W-1:0] regs_q [REG_CNT];

  logic [DATA_W-1:0] rsp_data_q;
  logic [REG_AW-1:0] rsp_rd_q;
  logic              rsp_err_q;
  logic              rsp_zero_q;
  logic              rsp_neg_q;

  logic [DATA_W-1:0] opa_d, opb_d;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] result_d;
  logic              illegal_d;
  logic              wr_en_d;

  // Operand fetch; R0 always reads zero
  always_comb begin
    opa_d = (req_q.rs1 == '0) ? '0 : regs_q[req_q.rs1];
    opb_d = (req_q.rs2 == '0) ? '0 : regs_q[req_q.rs2];
    if (req_q.use_imm) begin
      opb_d = req_q.imm;
    end
  end

  alu u_alu (
    .A      (opa_d),
    .B      (opb_d),
    .ALUOp  (req_q.op),
    .ALUOut (alu_out)
  );

  // Result shaping: illegal op and shifts by 16 or more yield zero
  always_comb begin
    illegal_d = (req_q.op == OP_ILLEGAL);
    result_d  = alu_out;
    if (illegal_d) begin
      result_d = '0;
    end else if (is_shift(req_q.op) && (opb_d[DATA_W-1:4] != '0)) begin
      result_d = '0;
    end
    wr_en_d = (state_q == ST_EXEC) && !illegal_d && (req_q.rd != '0);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ReqValid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (RspReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request capture, response registers and write-back
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
      rsp_err_q  <= 1'b0;
      rsp_zero_q <= 1'b1;
      rsp_neg_q  <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && ReqValid) begin
        req_q <= '{op: ReqOp, rd: ReqRd, rs1: ReqRs1, rs2: ReqRs2,
                   use_imm: ReqUseImm, imm: ReqImm};
      end
      if (state_q == ST_EXEC) begin
        rsp_data_q <= result_d;
        rsp_rd_q   <= req_q.rd;
        rsp_err_q  <= illegal_d;
        rsp_zero_q <= (result_d == '0);
        rsp_neg_q  <= result_d[DATA_W-1];
      end
      if (wr_en_d) begin
        regs_q[req_q.rd] <= result_d;
      end
    end
  end

  assign ReqReady = (state_q == ST_IDLE);
  assign RspValid = (state_q == ST_RESP);
  assign RspData  = rsp_data_q;
  assign RspRd    = rsp_rd_q;
  assign RspErr   = rsp_err_q;
  assign RspZero  = rsp_zero_q;
  assign RspNeg   = rsp_neg_q;
  assign DbgData  = (DbgAddr == '0) ? '0 : regs_q[DbgAddr];

endmodule
`default_nettype wire
